// File: rtl/control_path_driver.sv
// Control and memory block for a single-cycle word-addressed RV32I core: registered
// instruction ROM, combinational decode, word-wide data RAM. ROM initialised to NOP.
module control_path_driver #(
    parameter int IMEM_DW = 32,
    parameter int IMEM_AW = 4,
    parameter int DMEM_DW = 32,
    parameter int DMEM_AW = 16
) (
    input  logic               sysCLK,
    input  logic               pRST,
    input  logic [IMEM_AW-1:0] pcVal,
    output logic [IMEM_DW-1:0] inst,
    input  logic               BrEq,
    input  logic               BrLt,
    output logic               PCSel,
    output logic [2:0]         ImmSel,
    output logic               BrUn,
    output logic               ASel,
    output logic               BSel,
    output logic [3:0]         ALUSel,
    output logic               MemRW,
    output logic               RegWEn,
    output logic [1:0]         WBSel,
    input  logic [DMEM_AW-1:0] addrD,
    input  logic [DMEM_DW-1:0] memDataW,
    output logic [DMEM_DW-1:0] memDataR
);
    localparam logic [IMEM_DW-1:0] NOP = IMEM_DW'(32'h0000_0013);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    logic [IMEM_DW-1:0] rom [2**IMEM_AW] = '{default: NOP};

    logic [DMEM_DW-1:0] ram [2**DMEM_AW];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign funct7_5    = inst[30];
    assign unused_bits = ^{inst[IMEM_DW-1:31], inst[29:15], inst[11:7]};

    always_ff @(posedge sysCLK) begin
        if (pRST) inst <= NOP;
        else      inst <= rom[pcVal];
    end

    // alt selects SUB (funct3=000) or SRA (funct3=101); callers mask it for I-type
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        PCSel  = 1'b0;
        ImmSel = 3'b000;
        BrUn   = 1'b0;
        ASel   = 1'b0;
        BSel   = 1'b0;
        ALUSel = ALU_ADD;
        MemRW  = 1'b0;
        RegWEn = 1'b0;
        WBSel  = 2'b00;
        case (opcode)
            OP_R: begin
                RegWEn = 1'b1;
                ALUSel = alu_from_f3(funct3, funct7_5);
            end
            OP_I: begin
                BSel   = 1'b1;
                RegWEn = 1'b1;
                ALUSel = alu_from_f3(funct3, funct7_5 && funct3 == 3'b101);
            end
            OP_LW: begin
                BSel   = 1'b1;
                RegWEn = 1'b1;
                WBSel  = 2'b01;
            end
            OP_SW: begin
                ImmSel = 3'b001;
                BSel   = 1'b1;
                MemRW  = 1'b1;
            end
            OP_B: begin
                ImmSel = 3'b010;
                ASel   = 1'b1;
                BSel   = 1'b1;
                BrUn   = funct3[1];
                case (funct3)
                    3'b000:          PCSel = BrEq;
                    3'b001:          PCSel = !BrEq;
                    3'b100, 3'b110:  PCSel = BrLt;
                    3'b101, 3'b111:  PCSel = !BrLt;
                    default:         PCSel = 1'b0;
                endcase
            end
            OP_LUI: begin
                ImmSel = 3'b011;
                BSel   = 1'b1;
                ALUSel = ALU_PASSB;
                RegWEn = 1'b1;
            end
            OP_AUIPC: begin
                ImmSel = 3'b011;
                ASel   = 1'b1;
                BSel   = 1'b1;
                RegWEn = 1'b1;
            end
            OP_JAL: begin
                ImmSel = 3'b100;
                ASel   = 1'b1;
                BSel   = 1'b1;
                PCSel  = 1'b1;
                WBSel  = 2'b10;
                RegWEn = 1'b1;
            end
            OP_JALR: begin
                BSel   = 1'b1;
                PCSel  = 1'b1;
                WBSel  = 2'b10;
                RegWEn = 1'b1;
            end
            default: ;
        endcase
        // Reset suppresses every architectural side effect regardless of the held instruction
        if (pRST) begin
            MemRW  = 1'b0;
            RegWEn = 1'b0;
            PCSel  = 1'b0;
        end
    end

    always_ff @(posedge sysCLK) begin
        if (MemRW) ram[addrD] <= memDataW;
    end

    assign memDataR = ram[addrD];
endmodule

// File: tb/tb_control_path_driver.sv
// Directed bench for control_path_driver: ROM entries are placed hierarchically,
// then fetch/decode/RAM behaviour is compared against hand-computed values.
module tb_control_path_driver;
    logic        sysCLK = 1'b0;
    logic        pRST;
    logic [3:0]  pcVal;
    logic [31:0] inst;
    logic        BrEq, BrLt;
    logic        PCSel, BrUn, ASel, BSel, MemRW, RegWEn;
    logic [2:0]  ImmSel;
    logic [3:0]  ALUSel;
    logic [1:0]  WBSel;
    logic [15:0] addrD;
    logic [31:0] memDataW, memDataR;

    int compared   = 0;
    int mismatched = 0;

    control_path_driver dut (
        .sysCLK(sysCLK), .pRST(pRST), .pcVal(pcVal), .inst(inst),
        .BrEq(BrEq), .BrLt(BrLt), .PCSel(PCSel), .ImmSel(ImmSel), .BrUn(BrUn),
        .ASel(ASel), .BSel(BSel), .ALUSel(ALUSel), .MemRW(MemRW), .RegWEn(RegWEn),
        .WBSel(WBSel), .addrD(addrD), .memDataW(memDataW), .memDataR(memDataR)
    );

    always #5 sysCLK = ~sysCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysCLK);
        #1;
    endtask

    task automatic fetch(input logic [3:0] a);
        pcVal = a;
        tick();
    endtask

    initial begin
        pRST = 1'b1; pcVal = 4'd0; BrEq = 1'b0; BrLt = 1'b0;
        addrD = 16'h0; memDataW = 32'h0;
        #1;
        dut.rom[0]  = 32'h0000_0063; // BEQ
        dut.rom[1]  = 32'h0000_1063; // BNE
        dut.rom[2]  = 32'h0000_6063; // BLTU
        dut.rom[3]  = 32'h0020_8033; // ADD
        dut.rom[4]  = 32'h0020_A023; // SW
        dut.rom[5]  = 32'h0001_2083; // LW
        dut.rom[6]  = 32'h0000_006F; // JAL
        dut.rom[7]  = 32'h0000_0037; // LUI
        dut.rom[8]  = 32'h0000_007F; // unknown opcode
        dut.rom[9]  = 32'h4020_8033; // SUB
        dut.rom[10] = 32'h4000_5013; // SRAI
        dut.rom[11] = 32'h4000_0013; // ADDI with imm bit 30 set: still ADD
        dut.rom[12] = 32'h0000_5063; // BGE
        dut.rom[13] = 32'h0000_2063; // funct3=010 branch: never taken
        dut.rom[14] = 32'h0000_0067; // JALR

        tick();
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_memrw", 32'(MemRW), 32'd0);
        check("rst_regwen", 32'(RegWEn), 32'd0);
        pRST = 1'b0;
        #1;
        check("nop_regwen", 32'(RegWEn), 32'd1);
        check("nop_bsel", 32'(BSel), 32'd1);

        fetch(4'd3);
        check("add_inst", inst, 32'h0020_8033);
        check("add_ctrl", {RegWEn, ASel, BSel, ALUSel, WBSel}, {1'b1, 1'b0, 1'b0, 4'd0, 2'b00});

        fetch(4'd4); // SW now held in inst
        check("sw_ctrl", {ImmSel, BSel, MemRW, RegWEn}, {3'b001, 1'b1, 1'b1, 1'b0});
        addrD = 16'h0010; memDataW = 32'h1111_1111;
        tick();      // inst still SW (pcVal=4): writes 1111_1111
        check("sw_first", memDataR, 32'h1111_1111);
        memDataW = 32'hDEAD_BEEF;
        #1;
        check("rdw_old", memDataR, 32'h1111_1111);
        fetch(4'd5); // edge writes DEADBEEF and loads LW
        check("sw_data", memDataR, 32'hDEAD_BEEF);
        check("lw_ctrl", {WBSel, MemRW, RegWEn, BSel}, {2'b01, 1'b0, 1'b1, 1'b1});

        // store held under reset must not write
        fetch(4'd4);
        addrD = 16'h0020; memDataW = 32'h5555_AAAA;
        tick();
        check("pre_rst_wr", memDataR, 32'h5555_AAAA);
        memDataW = 32'h0BAD_F00D;
        pRST = 1'b1;
        #1;
        check("rst_sw_memrw", 32'(MemRW), 32'd0);
        tick();
        pRST = 1'b0;
        #1;
        check("rst_no_write", memDataR, 32'h5555_AAAA);

        fetch(4'd0);
        BrEq = 1'b1; #1;
        check("beq_taken", {PCSel, ImmSel, ASel, BSel, BrUn}, {1'b1, 3'b010, 1'b1, 1'b1, 1'b0});
        BrEq = 1'b0; #1;
        check("beq_not", 32'(PCSel), 32'd0);
        fetch(4'd1);
        check("bne_taken", 32'(PCSel), 32'd1);
        fetch(4'd2);
        BrLt = 1'b1; #1;
        check("bltu", {BrUn, PCSel}, {1'b1, 1'b1});
        fetch(4'd12);
        check("bge_not", {BrUn, PCSel}, {1'b0, 1'b0});
        BrLt = 1'b0; #1;
        check("bge_taken", 32'(PCSel), 32'd1);
        fetch(4'd13);
        BrEq = 1'b1; BrLt = 1'b1; #1;
        check("b010_never", {BrUn, PCSel}, {1'b1, 1'b0});
        BrEq = 1'b0; BrLt = 1'b0; #1;
        check("b010_never2", 32'(PCSel), 32'd0);

        fetch(4'd6);
        check("jal", {ImmSel, PCSel, WBSel, RegWEn, ASel, BSel}, {3'b100, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1});
        pRST = 1'b1; #1;
        check("jal_rst_pcsel", {PCSel, RegWEn}, {1'b0, 1'b0});
        pRST = 1'b0;
        fetch(4'd7);
        check("lui", {ImmSel, ALUSel, BSel, RegWEn}, {3'b011, 4'd10, 1'b1, 1'b1});
        fetch(4'd8);
        check("unknown", {RegWEn, MemRW, PCSel, ImmSel, BSel, ALUSel, WBSel}, 13'd0);
        fetch(4'd9);
        check("sub", 32'(ALUSel), 32'd1);
        fetch(4'd10);
        check("srai", {ALUSel, BSel}, {4'd7, 1'b1});
        fetch(4'd11);
        check("addi_f7", 32'(ALUSel), 32'd0);
        fetch(4'd14);
        check("jalr", {PCSel, WBSel, BSel, ASel, ImmSel}, {1'b1, 2'b10, 1'b1, 1'b0, 3'b000});
        fetch(4'd15);
        check("rom_default", inst, 32'h0000_0013);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
